// File: rtl/mul_issue_ctrl_pkg.sv
// Shared CPU definitions: ALU-control codes, ALUOp classes
// and the multiply-issue FSM state encoding.
package mul_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_ADD = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_MUL = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_SRA = 4'b1001,
    ALU_BEQ = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: operand shifters,
// accumulator and the adder producing the next partial sum.
module mul_shift_add_dp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  assign sum = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// EX-stage multicycle multiply issue control: stalls the
// pipeline while a 1-bit-per-cycle shift-add multiply runs.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter logic [3:0] MUL_CODE = ALU_MUL
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [3:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  mul_state_e      state;
  logic [CW-1:0]   cnt;
  logic            start;
  logic            step;
  logic [XLEN-1:0] sum;

  assign start = valid_i && (alu_ctrl_i == MUL_CODE) && !flush_i;
  assign step  = (state == BUSY) && !flush_i;

  // The request cycle itself must already hold the pipeline.
  assign stall_o = !rst_i &&
                   (((state == IDLE) && start) || (state == BUSY));

  mul_shift_add_dp #(
    .XLEN (XLEN)
  ) u_dp (
    .clk  (clk_i),
    .rst  (rst_i),
    .load ((state == IDLE) && start),
    .step (step),
    .a    (src1_i),
    .b    (src2_i),
    .sum  (sum)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= BUSY;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= sum;
            end
          end
        end
        DONE: begin
          // Result is already committed, so flush is ignored here.
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: vector table of
// multiplies/aborts plus reset corner sequences.
module tb_mul_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  alu_ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        valid;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    int          fk;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];
  int   done_at [NV];

  mul_issue_ctrl #(
    .XLEN     (32),
    .MUL_CODE (4'b0101)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .alu_ctrl_i (alu_ctrl_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // fk: cycle index (0 = request cycle) at which flush_i is
  // pulsed, -1 for none.
  task automatic run_vec(input int idx, input vec_t v,
                         output int dcyc);
    logic mul;
    logic ab;
    int   last_s;
    int   last_b;
    int   bad_s;
    int   bad_b;
    int   bad_d;
    logic [31:0] res;
    mul    = v.valid && (v.code == 4'b0101) && (v.fk != 0);
    ab     = mul && (v.fk >= 1) && (v.fk <= 32);
    last_s = !mul ? -1 : (ab ? v.fk : 32);
    last_b = !mul ? 0 : (ab ? v.fk : 33);
    bad_s  = 0;
    bad_b  = 0;
    bad_d  = 0;
    dcyc   = -1;
    res    = '0;
    valid_i    = v.valid;
    alu_ctrl_i = v.code;
    src1_i     = v.a;
    src2_i     = v.b;
    flush_i    = (v.fk == 0);
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk_i);
      if (stall_o !== (k <= last_s)) bad_s++;
      if (busy_o !== (k >= 1 && k <= last_b)) bad_b++;
      if (done_o !== (mul && !ab && k == 33)) bad_d++;
      if (done_o === 1'b1) dcyc = cyc;
      if (k == 33) res = result_o;
      @(posedge clk_i);
      #1;
      valid_i    = 1'b0;
      alu_ctrl_i = 4'b0000;
      flush_i    = (k + 1 == v.fk);
    end
    check($sformatf("v%0d_stall", idx), bad_s, 0);
    check($sformatf("v%0d_busy", idx), bad_b, 0);
    check($sformatf("v%0d_done", idx), bad_d, 0);
    check($sformatf("v%0d_result", idx), res, v.exp);
  endtask

  initial begin
    int d;
    vt[0]  = '{1, 4'b0101, 32'd7, 32'd6, -1, 32'd42};
    vt[1]  = '{1, 4'b0011, 32'd9, 32'd9, -1, 32'd42};
    vt[2]  = '{1, 4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'h1};
    vt[3]  = '{1, 4'b0101, 32'h00010000, 32'h00010000, -1, 32'h0};
    vt[4]  = '{1, 4'b0101, 32'h12345678, 32'd9, -1, 32'hA3D70A38};
    vt[5]  = '{1, 4'b0101, 32'hFFFFFFFD, 32'd7, -1, 32'hFFFFFFEB};
    vt[6]  = '{1, 4'b0101, 32'd9, 32'd9, 10, 32'hFFFFFFEB};
    vt[7]  = '{1, 4'b0101, 32'd9, 32'd9, 0, 32'hFFFFFFEB};
    vt[8]  = '{0, 4'b0101, 32'd9, 32'd9, -1, 32'hFFFFFFEB};
    vt[9]  = '{1, 4'b0101, 32'd11, 32'd13, 33, 32'd143};
    vt[10] = '{1, 4'b0101, 32'h0000FFFF, 32'd3, 32, 32'd143};
    vt[11] = '{1, 4'b0101, 32'd2, 32'd3, -1, 32'd6};
    vt[12] = '{1, 4'b0101, 32'd4, 32'd5, -1, 32'd20};

    rst_i      = 1'b1;
    valid_i    = 1'b1;
    alu_ctrl_i = 4'b0101;
    src1_i     = 32'd5;
    src2_i     = 32'd5;
    flush_i    = 1'b0;
    #12;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vt[i], d);
      done_at[i] = d;
    end
    check("b2b_spacing", done_at[12] - done_at[11], 32'd34);

    valid_i    = 1'b1;
    alu_ctrl_i = 4'b0101;
    src1_i     = 32'd100;
    src2_i     = 32'd100;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    run_vec(99, '{1, 4'b0101, 32'd3, 32'd5, -1, 32'd15}, d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
